// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
// Segment vectors are ordered {g,f,e,d,c,b,a}; a logical 1 lights a segment.
package seg7_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] GLYPH_0    = 7'b0111111;
  localparam logic [6:0] GLYPH_1    = 7'b0000110;
  localparam logic [6:0] GLYPH_2    = 7'b1011011;
  localparam logic [6:0] GLYPH_3    = 7'b1001111;
  localparam logic [6:0] GLYPH_4    = 7'b1100110;
  localparam logic [6:0] GLYPH_5    = 7'b1101101;
  localparam logic [6:0] GLYPH_6    = 7'b1111101;
  localparam logic [6:0] GLYPH_7    = 7'b0000111;
  localparam logic [6:0] GLYPH_8    = 7'b1111111;
  localparam logic [6:0] GLYPH_9    = 7'b1101111;
  localparam logic [6:0] GLYPH_A    = 7'b1110111;
  localparam logic [6:0] GLYPH_B    = 7'b1111100;
  localparam logic [6:0] GLYPH_C    = 7'b0111001;
  localparam logic [6:0] GLYPH_D    = 7'b1011110;
  localparam logic [6:0] GLYPH_E    = 7'b1111001;
  localparam logic [6:0] GLYPH_F    = 7'b1110001;
  localparam logic [6:0] GLYPH_DASH = 7'b1000000;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational nibble-to-glyph decoder; in BCD mode the non-decimal codes
// A..F render as a single dash on segment g.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = GLYPH_DASH;
    case (i_nibble)
      4'h0: o_seg = GLYPH_0;
      4'h1: o_seg = GLYPH_1;
      4'h2: o_seg = GLYPH_2;
      4'h3: o_seg = GLYPH_3;
      4'h4: o_seg = GLYPH_4;
      4'h5: o_seg = GLYPH_5;
      4'h6: o_seg = GLYPH_6;
      4'h7: o_seg = GLYPH_7;
      4'h8: o_seg = GLYPH_8;
      4'h9: o_seg = GLYPH_9;
      4'hA: o_seg = i_hex_mode ? GLYPH_A : GLYPH_DASH;
      4'hB: o_seg = i_hex_mode ? GLYPH_B : GLYPH_DASH;
      4'hC: o_seg = i_hex_mode ? GLYPH_C : GLYPH_DASH;
      4'hD: o_seg = i_hex_mode ? GLYPH_D : GLYPH_DASH;
      4'hE: o_seg = i_hex_mode ? GLYPH_E : GLYPH_DASH;
      4'hF: o_seg = i_hex_mode ? GLYPH_F : GLYPH_DASH;
      default: o_seg = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit time-multiplexed 7-segment driver with a blanking gap before each
// digit, frame-aligned double buffering and optional leading-zero suppression.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NDIGITS          = 4,
  parameter int PRESCALE_BITS    = 12,
  parameter int BLANK_CYCLES     = 16,
  parameter bit SEG_ACTIVE_LOW   = 1'b0,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [4*NDIGITS-1:0]   i_vals,
  input  logic [NDIGITS-1:0]     i_dps,
  input  logic                   i_load,
  input  logic                   i_hex_mode,
  input  logic                   i_lz_blank,
  output logic [6:0]             o_seg,
  output logic                   o_dp,
  output logic [NDIGITS-1:0]     o_digit_en,
  output logic                   o_frame
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PRESCALE_BITS-1:0] BLANK_LAST = PRESCALE_BITS'(BLANK_CYCLES - 1);
  localparam logic [PRESCALE_BITS-1:0] SHOW_LAST  = '1;
  localparam logic [IDX_W-1:0]         IDX_LAST   = IDX_W'(NDIGITS - 1);

  state_t                   r_state, w_nstate;
  logic [IDX_W-1:0]         r_idx, w_nidx;
  logic [PRESCALE_BITS-1:0] r_cnt, w_ncnt;
  logic                     r_started;

  logic [4*NDIGITS-1:0]     r_pend_vals, r_act_vals;
  logic [NDIGITS-1:0]       r_pend_dps, r_act_dps;

  logic [6:0]               r_seg;
  logic                     r_dp;
  logic [NDIGITS-1:0]       r_digit_en;
  logic                     r_frame;

  logic                     w_boundary;
  logic [3:0]               w_nibble;
  logic                     w_dp_bit;
  logic                     w_suppress;
  logic [NDIGITS-1:0]       w_onehot;
  logic [NDIGITS-1:0]       w_lz_mask;
  logic                     w_upper_zero;
  logic [6:0]               w_glyph;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_BLANK;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_idx     <= w_nidx;
      r_cnt     <= w_ncnt;
      r_started <= 1'b1;
    end
  end

  // The first edge out of reset holds position so that cycle 0 is the
  // digit-0 blank start and carries the frame pulse.
  always_comb begin
    w_nstate = r_state;
    w_nidx   = r_idx;
    w_ncnt   = r_cnt;
    if (r_started) begin
      if (r_state == S_BLANK) begin
        if (r_cnt == BLANK_LAST) begin
          w_nstate = S_SHOW;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + 1'b1;
        end
      end else begin
        if (r_cnt == SHOW_LAST) begin
          w_nstate = S_BLANK;
          w_ncnt   = '0;
          w_nidx   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
          w_ncnt = r_cnt + 1'b1;
        end
      end
    end
  end

  assign w_boundary = (w_nstate == S_BLANK) && (w_nidx == '0) && (w_ncnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_vals <= '0;
      r_pend_dps  <= '0;
      r_act_vals  <= '0;
      r_act_dps   <= '0;
    end else begin
      if (i_load) begin
        r_pend_vals <= i_vals;
        r_pend_dps  <= i_dps;
      end
      if (w_boundary) begin
        r_act_vals <= i_load ? i_vals : r_pend_vals;
        r_act_dps  <= i_load ? i_dps  : r_pend_dps;
      end
    end
  end

  // Bit k set when digit k and every digit above it has zero nibble and no dp.
  always_comb begin
    w_lz_mask    = '0;
    w_upper_zero = 1'b1;
    for (int k = NDIGITS - 1; k >= 1; k--) begin
      w_upper_zero = w_upper_zero && (r_act_vals[4*k +: 4] == 4'd0) && !r_act_dps[k];
      w_lz_mask[k] = w_upper_zero;
    end
  end

  always_comb begin
    w_nibble   = '0;
    w_dp_bit   = 1'b0;
    w_suppress = 1'b0;
    w_onehot   = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (w_nidx == IDX_W'(k)) begin
        w_nibble    = r_act_vals[4*k +: 4];
        w_dp_bit    = r_act_dps[k];
        w_suppress  = i_lz_blank && w_lz_mask[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  seg7_glyph_decode u_decode (
    .i_nibble   (w_nibble),
    .i_hex_mode (i_hex_mode),
    .o_seg      (w_glyph)
  );

  // Output registers are fed from next-state so they move with state/index.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seg      <= '0;
      r_dp       <= 1'b0;
      r_digit_en <= '0;
      r_frame    <= 1'b0;
    end else begin
      r_frame <= w_boundary;
      if (w_nstate == S_SHOW) begin
        r_digit_en <= w_onehot;
        r_seg      <= w_suppress ? '0 : w_glyph;
        r_dp       <= w_suppress ? 1'b0 : w_dp_bit;
      end else begin
        r_digit_en <= '0;
        r_seg      <= '0;
        r_dp       <= 1'b0;
      end
    end
  end

  assign o_seg      = r_seg ^ {7{SEG_ACTIVE_LOW}};
  assign o_dp       = r_dp ^ SEG_ACTIVE_LOW;
  assign o_digit_en = r_digit_en ^ {NDIGITS{DIGIT_ACTIVE_LOW}};
  assign o_frame    = r_frame;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux with 4 digits, 8-cycle show, 2-cycle blank.
module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int PB = 3;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] vals;
  logic [3:0]  dps;
  logic        load;
  logic        hex;
  logic        lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  en;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NDIGITS          (ND),
    .PRESCALE_BITS    (PB),
    .BLANK_CYCLES     (BC),
    .SEG_ACTIVE_LOW   (1'b0),
    .DIGIT_ACTIVE_LOW (1'b0)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_vals     (vals),
    .i_dps      (dps),
    .i_load     (load),
    .i_hex_mode (hex),
    .i_lz_blank (lz),
    .o_seg      (seg),
    .o_dp       (dp),
    .o_digit_en (en),
    .o_frame    (frame)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] len;
  } slot_t;

  slot_t exp_q[$];
  slot_t obs_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011,
                         G3 = 7'b1001111, G4 = 7'b1100110, G9 = 7'b1101111,
                         GDASH = 7'b1000000;

  // Slot monitor: one record per show period, taken just after each edge.
  logic [3:0] m_prev = 4'b0;
  logic [6:0] m_seg = '0;
  logic       m_dp = 1'b0;
  logic [7:0] m_len = '0;
  bit         m_stable = 1'b1;
  bit         mon_on = 1'b0;
  int         blank_bad = 0;

  always @(posedge clk) begin
    #1;
    if (en !== m_prev) begin
      if (!$isunknown(m_prev) && m_prev != 4'b0)
        obs_q.push_back('{en: m_prev, seg: m_seg, dp: m_dp, len: (m_stable ? m_len : 8'hFF)});
      m_seg    = seg;
      m_dp     = dp;
      m_len    = 8'd1;
      m_stable = 1'b1;
    end else if (!$isunknown(en) && en != 4'b0) begin
      m_len = m_len + 8'd1;
      if (seg !== m_seg || dp !== m_dp) m_stable = 1'b0;
    end
    if (mon_on && en === 4'b0 && (seg !== 7'b0 || dp !== 1'b0)) blank_bad++;
    m_prev = en;
  end

  task automatic push_slot(input int d, input logic [6:0] s, input logic p);
    exp_q.push_back('{en: 4'(1 << d), seg: s, dp: p, len: 8'd8});
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    vals = v;
    dps  = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] e_en;
    logic       e_fr;
    rst = 1'b1; load = 1'b0; vals = '0; dps = '0; hex = 1'b1; lz = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({en, seg, dp, frame} !== 13'b0) begin
        n_fail++;
        $display("FAIL reset_hold got en=%b seg=%b dp=%b frame=%b want all zero", en, seg, dp, frame);
      end
    end
    rst = 1'b0;
    mon_on = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      e_en = ((c % 10) >= 2) ? 4'(1 << ((c / 10) % 4)) : 4'b0;
      e_fr = (c == 0 || c == 40);
      n_tests++;
      if (en !== e_en || frame !== e_fr) begin
        n_fail++;
        $display("FAIL reset_sched cycle %0d got en=%b frame=%b want en=%b frame=%b", c, en, frame, e_en, e_fr);
      end
    end
  endtask

  task automatic test_hex_dp;
    bit ok1, ok2;
    slot_t e, o;
    hex = 1'b1; lz = 1'b0;
    do_load(16'h1234, 4'b0100);
    wait_frame(ok1);
    obs_q.delete();
    push_slot(0, G4, 1'b0); push_slot(1, G3, 1'b0); push_slot(2, G2, 1'b1); push_slot(3, G1, 1'b0);
    wait_frame(ok2);
    n_tests++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL hex_frame_wait got timeout want frame pulse"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : slot_t'(0);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL hex_slot got en=%b seg=%b dp=%b len=%0d want en=%b seg=%b dp=%b len=%0d",
                 o.en, o.seg, o.dp, o.len, e.en, e.seg, e.dp, e.len);
      end
    end
  endtask

  task automatic test_lz;
    bit ok1, ok2;
    slot_t e, o;
    for (int pass = 0; pass < 2; pass++) begin
      hex = 1'b1; lz = 1'b1;
      do_load(16'h0040, (pass == 0) ? 4'b0000 : 4'b1000);
      wait_frame(ok1);
      obs_q.delete();
      push_slot(0, G0, 1'b0);
      push_slot(1, G4, 1'b0);
      push_slot(2, (pass == 0) ? 7'b0 : G0, 1'b0);
      push_slot(3, (pass == 0) ? 7'b0 : G0, (pass == 0) ? 1'b0 : 1'b1);
      wait_frame(ok2);
      n_tests++;
      if (!(ok1 && ok2)) begin n_fail++; $display("FAIL lz_frame_wait pass %0d got timeout want frame pulse", pass); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : slot_t'(0);
        n_tests++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL lz_slot pass %0d got en=%b seg=%b dp=%b len=%0d want en=%b seg=%b dp=%b len=%0d",
                   pass, o.en, o.seg, o.dp, o.len, e.en, e.seg, e.dp, e.len);
        end
      end
    end
  endtask

  task automatic test_bcd;
    bit ok1, ok2;
    slot_t e, o;
    hex = 1'b0; lz = 1'b0;
    do_load(16'h00A9, 4'b0000);
    wait_frame(ok1);
    obs_q.delete();
    push_slot(0, G9, 1'b0); push_slot(1, GDASH, 1'b0); push_slot(2, G0, 1'b0); push_slot(3, G0, 1'b0);
    wait_frame(ok2);
    n_tests++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL bcd_frame_wait got timeout want frame pulse"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : slot_t'(0);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bcd_slot got en=%b seg=%b dp=%b len=%0d want en=%b seg=%b dp=%b len=%0d",
                 o.en, o.seg, o.dp, o.len, e.en, e.seg, e.dp, e.len);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    slot_t e, o;
    logic [6:0] g;
    hex = 1'b1; lz = 1'b0;
    do_load(16'h2222, 4'b0000);
    wait_frame(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL dbuf_settle got timeout want frame pulse"); end
    // Phase 0: mid-frame load must not tear; 1: it shows next frame;
    // 2: boundary-edge load shows at once; 3: and persists from pending.
    for (int ph = 0; ph < 4; ph++) begin
      obs_q.delete();
      g = (ph == 0) ? G2 : (ph == 1) ? G1 : G3;
      for (int d = 0; d < 4; d++) push_slot(d, g, 1'b0);
      if (ph == 0) begin
        repeat (14) @(negedge clk);
        do_load(16'h1111, 4'b0000);
      end
      if (ph == 2) begin
        obs_q.delete();
        repeat (40) @(negedge clk);
      end
      wait_frame(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL dbuf_frame_wait phase %0d got timeout want frame pulse", ph); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : slot_t'(0);
        n_tests++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL dbuf_slot phase %0d got en=%b seg=%b dp=%b len=%0d want en=%b seg=%b dp=%b len=%0d",
                   ph, o.en, o.seg, o.dp, o.len, e.en, e.seg, e.dp, e.len);
        end
      end
      if (ph == 1) begin
        // Now at cycle 0 of a frame showing 1111; load on the next boundary edge.
        repeat (39) @(negedge clk);
        vals = 16'h3333;
        dps  = 4'b0000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_tests++;
        if (frame !== 1'b1) begin
          n_fail++;
          $display("FAIL dbuf_boundary_align got frame=%b want 1", frame);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    slot_t e, o;
    hex = 1'b1; lz = 1'b1;
    wait_frame(ok);
    repeat (24) @(negedge clk);
    n_tests++;
    if (en !== 4'b0100) begin n_fail++; $display("FAIL rstmid_pre got en=%b want 0100", en); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({en, seg, dp, frame} !== 13'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear got en=%b seg=%b dp=%b frame=%b want all zero", en, seg, dp, frame);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (frame !== 1'b1 || en !== 4'b0) begin
      n_fail++;
      $display("FAIL rstmid_restart got frame=%b en=%b want frame=1 en=0000", frame, en);
    end
    obs_q.delete();
    push_slot(0, G0, 1'b0); push_slot(1, 7'b0, 1'b0); push_slot(2, 7'b0, 1'b0); push_slot(3, 7'b0, 1'b0);
    wait_frame(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_frame_wait got timeout want frame pulse"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : slot_t'(0);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rstmid_slot got en=%b seg=%b dp=%b len=%0d want en=%b seg=%b dp=%b len=%0d",
                 o.en, o.seg, o.dp, o.len, e.en, e.seg, e.dp, e.len);
      end
    end
    n_tests++;
    if (blank_bad != 0) begin
      n_fail++;
      $display("FAIL blank_quiet got %0d lit blank cycles want 0", blank_bad);
    end
  endtask

  initial begin
    test_reset();
    test_hex_dp();
    test_lz();
    test_bcd();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
